// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped BTB with 2-bit counters for fetch-stage next-PC prediction
// Lookup is combinational on the fetch PC; the execute side trains the table one cycle later.
module branch_predictor_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_next_pc,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_is_jump,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_tgt_pc,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] stat_lookups,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [XLEN-1:0]  tbl_target [ENTRIES];
  logic [1:0]       tbl_ctr    [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] f_tag;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Upper PC bits above the tag and the halfword offset take no part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0],
                            fetch_pc[XLEN-1:IDX_W+TAG_W+2], upd_pc[XLEN-1:IDX_W+TAG_W+2]};

  assign pred_hit     = fetch_valid & tbl_valid[f_idx] & (tbl_tag[f_idx] == f_tag);
  assign pred_taken   = pred_hit & tbl_ctr[f_idx][1];
  assign pred_next_pc = pred_taken ? tbl_target[f_idx] : fetch_pc + XLEN'(4);

  assign u_hit = tbl_valid[u_idx] & (tbl_tag[u_idx] == u_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_ctr[i]    <= 2'b01;
      end
    end else if (flush) begin
      // Counters and targets survive a flush; only the valid bits drop.
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_is_jump) begin
          tbl_ctr[u_idx]    <= 2'b11;
          tbl_target[u_idx] <= upd_tgt_pc;
        end else if (upd_taken) begin
          if (tbl_ctr[u_idx] != 2'b11) begin
            tbl_ctr[u_idx] <= tbl_ctr[u_idx] + 2'd1;
          end
          tbl_target[u_idx] <= upd_tgt_pc;
        end else if (tbl_ctr[u_idx] != 2'b00) begin
          tbl_ctr[u_idx] <= tbl_ctr[u_idx] - 2'd1;
        end
      end else if (upd_taken | upd_is_jump) begin
        tbl_valid[u_idx]  <= 1'b1;
        tbl_tag[u_idx]    <= u_tag;
        tbl_target[u_idx] <= upd_tgt_pc;
        tbl_ctr[u_idx]    <= upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (fetch_valid && stat_lookups != '1) begin
        stat_lookups <= stat_lookups + CNT_W'(1);
      end
      if (upd_valid && upd_mispredict && stat_mispredicts != '1) begin
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - scoreboard bench for branch_predictor_btb
// A second instance with 4-bit counters exercises perf-counter saturation on the same stimulus.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_tgt_pc;
  logic        upd_mispredict;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;
  logic        s_hit;
  logic        s_taken;
  logic [31:0] s_next;
  logic [3:0]  s_lookups;
  logic [3:0]  s_misp;

  always #5 clk = ~clk;

  branch_predictor_btb #(.XLEN(32), .ENTRIES(64), .TAG_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_tgt_pc(upd_tgt_pc), .upd_mispredict(upd_mispredict),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor_btb #(.XLEN(32), .ENTRIES(64), .TAG_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_hit(s_hit), .pred_taken(s_taken), .pred_next_pc(s_next),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_tgt_pc(upd_tgt_pc), .upd_mispredict(upd_mispredict),
    .stat_lookups(s_lookups), .stat_mispredicts(s_misp)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   n_look = 0;
  int   n_misp = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return {31'b0, pred_hit};
      1:       return {31'b0, pred_taken};
      2:       return pred_next_pc;
      3:       return stat_lookups;
      4:       return stat_mispredicts;
      5:       return {28'b0, s_lookups};
      6:       return {28'b0, s_misp};
      default: return 32'hdead_beef;
    endcase
  endfunction

  function automatic int sat15(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic idle();
    fetch_valid    = 1'b0;
    upd_valid      = 1'b0;
    upd_is_jump    = 1'b0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic h, input logic t,
                       input logic [31:0] nx, input string tag);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    expect_out({tag, ".hit"},   0, {31'b0, h});
    expect_out({tag, ".taken"}, 1, {31'b0, t});
    expect_out({tag, ".next"},  2, nx);
  endtask

  task automatic upd(input logic [31:0] pc, input logic jump, input logic taken,
                     input logic [31:0] tgt, input logic misp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_is_jump    = jump;
    upd_taken      = taken;
    upd_tgt_pc     = tgt;
    upd_mispredict = misp;
  endtask

  task automatic push_stats();
    expect_out("stat_lookups",     3, n_look);
    expect_out("stat_mispredicts", 4, n_misp);
    expect_out("sat_lookups",      5, sat15(n_look));
    expect_out("sat_mispredicts",  6, sat15(n_misp));
  endtask

  // Lookups are checked before the edge that applies this cycle's update.
  task automatic step();
    push_stats();
    if (rst_n) begin
      if (fetch_valid) n_look++;
      if (upd_valid && upd_mispredict) n_misp++;
    end
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    fetch_pc   = 32'h0;
    upd_pc     = 32'h0;
    upd_tgt_pc = 32'h0;
    idle();
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    #1;
    expect_out("rst.hit",   0, 32'h0);
    expect_out("rst.taken", 1, 32'h0);
    expect_out("rst.next",  2, 32'h104);
    push_stats();
    drain();
    repeat (2) @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;

    fetch(32'h100, 0, 0, 32'h104, "cold"); step();
    step();
    upd(32'h100, 0, 1, 32'h80, 0); step();
    fetch(32'h100, 1, 1, 32'h80, "alloc"); step();

    upd(32'h100, 0, 0, 32'h999, 0); step();
    fetch(32'h100, 1, 0, 32'h104, "ctr1"); step();
    upd(32'h100, 0, 0, 32'h999, 0); step();
    fetch(32'h100, 1, 0, 32'h104, "ctr0"); step();
    upd(32'h100, 0, 0, 32'h999, 0); step();
    fetch(32'h100, 1, 0, 32'h104, "ctr0_hold"); step();
    upd(32'h100, 0, 1, 32'h90, 0); step();
    fetch(32'h100, 1, 0, 32'h104, "ctr1_up"); step();
    upd(32'h100, 0, 1, 32'h90, 0); step();
    fetch(32'h100, 1, 1, 32'h90, "ctr2_up"); step();
    upd(32'h100, 0, 1, 32'h90, 0); step();
    upd(32'h100, 0, 1, 32'h90, 0); step();
    upd(32'h100, 0, 0, 32'h999, 0); step();
    fetch(32'h100, 1, 1, 32'h90, "sat3_nt"); step();
    upd(32'h100, 0, 0, 32'h999, 0); step();
    fetch(32'h100, 1, 0, 32'h104, "ctr1_again"); step();

    upd(32'h200, 0, 1, 32'h300, 0);
    fetch(32'h200, 0, 0, 32'h204, "alias_same_cycle"); step();
    fetch(32'h200, 1, 1, 32'h300, "alias_next"); step();
    fetch(32'h100, 0, 0, 32'h104, "alias_evicted"); step();
    upd(32'h500, 0, 0, 32'h555, 0); step();
    fetch(32'h500, 0, 0, 32'h504, "miss_nt_noalloc"); step();
    fetch(32'h200, 1, 1, 32'h300, "alias_kept"); step();

    upd(32'h40, 1, 1, 32'h1234, 1); step();
    fetch(32'h40, 1, 1, 32'h1234, "jalr"); step();
    fetch(32'h42, 1, 1, 32'h1234, "jalr_lowbits"); step();
    upd(32'h40, 0, 0, 32'h0, 1); step();
    fetch(32'h40, 1, 1, 32'h1234, "jalr_ctr2"); step();
    upd(32'h40, 0, 0, 32'h0, 1); step();
    fetch(32'h40, 1, 0, 32'h44, "jalr_ctr1"); step();
    fetch(32'hFFFF_FFFC, 0, 0, 32'h0, "wrap"); step();

    upd(32'h700, 0, 0, 32'h0, 1); step();
    upd(32'h700, 0, 0, 32'h0, 1); step();
    step();

    flush = 1'b1;
    upd(32'h600, 0, 1, 32'h700, 0); step();
    fetch(32'h40,  0, 0, 32'h44,  "flush_jalr"); step();
    fetch(32'h200, 0, 0, 32'h204, "flush_alias"); step();
    fetch(32'h600, 0, 0, 32'h604, "flush_upd_dropped"); step();

    upd(32'h100, 0, 1, 32'h80, 0); step();
    fetch(32'h100, 1, 1, 32'h80, "pre_reset"); step();
    rst_n       = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    #1;
    n_look = 0;
    n_misp = 0;
    expect_out("midrst.hit",   0, 32'h0);
    expect_out("midrst.taken", 1, 32'h0);
    expect_out("midrst.next",  2, 32'h104);
    push_stats();
    drain();
    @(posedge clk);
    #1;
    push_stats();
    drain();
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fetch(32'h100, 0, 0, 32'h104, "post_reset"); step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
